// File: rtl/firefly_led_pkg.sv
// Shared types and default constants for the firefly LED breathing generator.
// FIREFLY_LED_GAMMA_EN selects a squared duty curve for the breathing ramp.
package firefly_led_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OUT_RUN,
    TEST_RUN
  } state_e;

  localparam int PERIOD_DEF = 16;
  localparam int LEVELS_DEF = 16;

endpackage

// File: rtl/firefly_pwm_engine.sv
// One PWM window: len cycles, led high while the index is below duty.
// A start in the same cycle as done chains the next window with no gap.
module firefly_pwm_engine
  import firefly_led_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] duty_i,
  input  logic [31:0] len_i,
  output logic        led_o,
  output logic        wr_o,
  output logic        done_o
);

  logic        active_q;
  logic [31:0] i_q;
  logic [31:0] i_d;
  logic [31:0] duty_q;
  logic [31:0] len_q;
  logic        empty;

  assign empty  = (len_q == 32'd0);
  assign led_o  = (i_q < duty_q);
  assign wr_o   = active_q && !empty;
  assign done_o = active_q && (empty || (i_q == len_q - 32'd1));
  assign i_d    = i_q + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      i_q      <= '0;
      duty_q   <= '0;
      len_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      i_q      <= '0;
      duty_q   <= duty_i;
      len_q    <= len_i;
    end else if (active_q) begin
      if (done_o) active_q <= 1'b0;
      else        i_q      <= i_d;
    end
  end

endmodule

// File: rtl/firefly_led.sv
// Firefly LED breathing generator: pwm_out / pwm_test calls over one engine.
// FIREFLY_LED_GAMMA_EN: ramp duty at step d becomes (d*d)/LEVELS.
module firefly_led
  import firefly_led_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEF,
  parameter int LEVELS = LEVELS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] c_in,
  input  logic        c_we,
  output logic [31:0] c_out,
  input  logic [31:0] pwm_out_a,
  input  logic [31:0] pwm_out_b,
  output logic        pwm_out_busy,
  input  logic        pwm_out_req,
  output logic        pwm_test_busy,
  input  logic        pwm_test_req
);

  localparam int DW = $clog2(LEVELS) + 1;

  state_e      state_q;
  logic [DW-1:0] d_q, d_d;
  logic        up_q, up_d;
  logic        out_busy_q;
  logic        test_busy_q;
  logic [31:0] c_q;

  logic        eng_start;
  logic [31:0] eng_duty;
  logic [31:0] eng_len;
  logic        eng_led;
  logic        eng_wr;
  logic        eng_done;

  function automatic logic [31:0] ramp_duty(input logic [DW-1:0] d);
`ifdef FIREFLY_LED_GAMMA_EN
    ramp_duty = (32'(d) * 32'(d)) / 32'(LEVELS);
`else
    ramp_duty = 32'(d);
`endif
  endfunction

  // Ramp walks 0..L-1 then L-1..0, repeating each end step once.
  always_comb begin
    d_d = d_q;
    up_d = up_q;
    if (up_q) begin
      if (d_q == DW'(LEVELS - 1)) up_d = 1'b0;
      else                        d_d  = d_q + 1'b1;
    end else begin
      if (d_q == '0) up_d = 1'b1;
      else           d_d  = d_q - 1'b1;
    end
  end

  always_comb begin
    eng_start = 1'b0;
    eng_duty  = '0;
    eng_len   = '0;
    unique case (state_q)
      IDLE: begin
        if (pwm_test_req) begin
          eng_start = 1'b1;
          eng_duty  = ramp_duty('0);
          eng_len   = 32'(PERIOD);
        end else if (pwm_out_req) begin
          eng_start = 1'b1;
          eng_duty  = pwm_out_a;
          eng_len   = pwm_out_b;
        end
      end
      TEST_RUN: begin
        if (eng_done) begin
          eng_start = 1'b1;
          eng_duty  = ramp_duty(d_d);
          eng_len   = 32'(PERIOD);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      d_q         <= '0;
      up_q        <= 1'b1;
      out_busy_q  <= 1'b0;
      test_busy_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          d_q  <= '0;
          up_q <= 1'b1;
          if (pwm_test_req) begin
            state_q     <= TEST_RUN;
            test_busy_q <= 1'b1;
          end else if (pwm_out_req) begin
            state_q    <= OUT_RUN;
            out_busy_q <= 1'b1;
          end
        end
        OUT_RUN: begin
          if (eng_done) begin
            state_q    <= IDLE;
            out_busy_q <= 1'b0;
          end
        end
        TEST_RUN: begin
          if (eng_done) begin
            d_q  <= d_d;
            up_q <= up_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       c_q <= '0;
    else if (c_we)   c_q <= c_in;
    else if (eng_wr) c_q <= {31'd0, eng_led};
  end

  firefly_pwm_engine u_engine (
    .clk     (clk),
    .reset   (reset),
    .start_i (eng_start),
    .duty_i  (eng_duty),
    .len_i   (eng_len),
    .led_o   (eng_led),
    .wr_o    (eng_wr),
    .done_o  (eng_done)
  );

  assign c_out         = c_q;
  assign pwm_out_busy  = out_busy_q;
  assign pwm_test_busy = test_busy_q;

endmodule

// File: tb/tb_firefly_led.sv
// Scoreboard bench for firefly_led: expected c_out values queued per cycle.
// Honours FIREFLY_LED_GAMMA_EN in the ramp model.
module tb_firefly_led;

  localparam int P = 16;
  localparam int L = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] c_in = '0;
  logic        c_we = 1'b0;
  logic [31:0] c_out;
  logic [31:0] pwm_out_a = '0;
  logic [31:0] pwm_out_b = '0;
  logic        pwm_out_busy;
  logic        pwm_out_req = 1'b0;
  logic        pwm_test_busy;
  logic        pwm_test_req = 1'b0;

  int vecs = 0;
  int errs = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_c = '0;
  logic [31:0] e;

  always #5 clk = ~clk;

  firefly_led #(.PERIOD(P), .LEVELS(L)) dut (
    .clk           (clk),
    .reset         (reset),
    .c_in          (c_in),
    .c_we          (c_we),
    .c_out         (c_out),
    .pwm_out_a     (pwm_out_a),
    .pwm_out_b     (pwm_out_b),
    .pwm_out_busy  (pwm_out_busy),
    .pwm_out_req   (pwm_out_req),
    .pwm_test_busy (pwm_test_busy),
    .pwm_test_req  (pwm_test_req)
  );

  function automatic int ramp_d(int t);
    int w;
    w = (t / P) % (2 * L);
    return (w < L) ? w : (2 * L - 1 - w);
  endfunction

  function automatic int duty_of(int d);
`ifdef FIREFLY_LED_GAMMA_EN
    return (d * d) / L;
`else
    return d;
`endif
  endfunction

  function automatic logic [31:0] ramp_exp(int t);
    return ((t % P) < duty_of(ramp_d(t))) ? 32'd1 : 32'd0;
  endfunction

  task automatic chk_busy(string nm, logic ob, logic tb_);
    vecs++;
    if (pwm_out_busy !== ob || pwm_test_busy !== tb_) begin
      errs++;
      $display("FAIL %s: busy out/test got %b/%b want %b/%b",
               nm, pwm_out_busy, pwm_test_busy, ob, tb_);
    end
  endtask

  task automatic chk_c(string nm);
    e = sb.pop_front();
    vecs++;
    if (c_out !== e) begin
      errs++;
      $display("FAIL %s: c_out got %h want %h", nm, c_out, e);
    end
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    exp_c = '0;
    sb.delete();
  endtask

  task automatic run_out(logic [31:0] a, logic [31:0] b);
    pwm_out_a = a;
    pwm_out_b = b;
    pwm_out_req = 1'b1;
    @(negedge clk);
    pwm_out_req = 1'b0;
    pwm_out_a = $urandom;
    pwm_out_b = $urandom;
    chk_busy("accept", 1'b1, 1'b0);
    if (b == 0) begin
      @(negedge clk);
      chk_busy("b0_busy_end", 1'b0, 1'b0);
      sb.push_back(exp_c);
      chk_c("b0_c_keep");
    end else begin
      for (logic [31:0] k = 0; k < b; k++) begin
        sb.push_back((k < a) ? 32'd1 : 32'd0);
        @(negedge clk);
        exp_c = sb[0];
        chk_c("out_seq");
        chk_busy("out_busy", (k != b - 1), 1'b0);
      end
    end
    @(negedge clk);
    chk_busy("idle_gap", 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset(3);
    reset = 1'b1;
    @(negedge clk);
    sb.push_back(32'd0);
    chk_c("reset_c");
    chk_busy("reset_busy", 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_pwm_out();
    run_out(32'd3, 32'd8);
    run_out(32'd10, 32'd4);
    run_out(32'd7, 32'd0);
    run_out(32'd0, 32'd3);
  endtask

  task automatic test_pwm_test();
    int ones[2*L];
    foreach (ones[i]) ones[i] = 0;
    repeat (2) @(negedge clk);
    do_reset(6);
    pwm_test_req = 1'b1;
    @(negedge clk);
    chk_busy("test_accept", 1'b0, 1'b1);
    for (int t = 0; t < 1600; t++) begin
      sb.push_back(ramp_exp(t));
      @(negedge clk);
      if (t < 2 * L * P && c_out === 32'd1) ones[t / P]++;
      chk_c("ramp");
      if (pwm_test_busy !== 1'b1) chk_busy("test_hold", 1'b0, 1'b1);
    end
    vecs++;
    if (ones[0] != 0) begin
      errs++;
      $display("FAIL win0: ones got %0d want 0", ones[0]);
    end
    vecs++;
`ifdef FIREFLY_LED_GAMMA_EN
    if (ones[15] != 14 || ones[8] != 4) begin
`else
    if (ones[15] != 15 || ones[8] != 8) begin
`endif
      errs++;
      $display("FAIL win15_win8: ones got %0d/%0d", ones[15], ones[8]);
    end
    pwm_test_req = 1'b0;
  endtask

  task automatic test_arb_and_cwe();
    do_reset(2);
    pwm_out_a = 32'd5;
    pwm_out_b = 32'd5;
    pwm_out_req = 1'b1;
    pwm_test_req = 1'b1;
    @(negedge clk);
    chk_busy("arb", 1'b0, 1'b1);
    for (int t = 0; t < 80; t++) begin
      if (t == 40) begin
        c_we = 1'b1;
        c_in = 32'hDEADBEEF;
        sb.push_back(32'hDEADBEEF);
      end else begin
        sb.push_back(ramp_exp(t));
      end
      @(negedge clk);
      c_we = 1'b0;
      chk_c((t == 40) ? "cwe" : "cwe_resume");
      if (t % 20 == 0) chk_busy("arb_hold", 1'b0, 1'b1);
    end
    pwm_out_req = 1'b0;
    pwm_test_req = 1'b0;
  endtask

  task automatic test_reset_abort();
    do_reset(2);
    pwm_out_a = 32'd8;
    pwm_out_b = 32'd8;
    pwm_out_req = 1'b1;
    @(negedge clk);
    pwm_out_req = 1'b0;
    repeat (2) @(negedge clk);
    sb.push_back(32'd1);
    chk_c("abort_pre");
    reset = 1'b1;
    c_we = 1'b1;
    c_in = 32'h1234_5678;
    @(negedge clk);
    reset = 1'b0;
    c_we = 1'b0;
    exp_c = '0;
    sb.push_back(32'd0);
    chk_c("abort_c");
    chk_busy("abort_busy", 1'b0, 1'b0);
    run_out(32'd5, 32'd6);
  endtask

  initial begin
    test_reset();
    test_pwm_out();
    test_pwm_test();
    test_arb_and_cwe();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
